// File: rtl/data_mem_responder_pkg.sv
// Shared constants and FSM encoding for the data-memory responder.
package data_mem_responder_pkg;

  localparam int unsigned DMEM_WORD_LEN   = 32;
  localparam int unsigned DMEM_DEPTH_LOG2 = 8;

  localparam logic DMEM_ST_INIT = 1'b0;
  localparam logic DMEM_ST_RUN  = 1'b1;

  typedef enum logic {
    StInit = DMEM_ST_INIT,
    StRun  = DMEM_ST_RUN
  } dmem_state_e;

endpackage

// File: rtl/dmem_array.sv
// Word-addressed storage: one synchronous write port, one combinational read port,
// and one registered read port for the host side.
module dmem_array #(
  parameter int unsigned WORD_LEN   = 32,
  parameter int unsigned DEPTH_LOG2 = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  we_i,
  input  logic [DEPTH_LOG2-1:0] waddr_i,
  input  logic [WORD_LEN-1:0]   wdata_i,
  input  logic [DEPTH_LOG2-1:0] raddr_i,
  output logic [WORD_LEN-1:0]   rdata_o,
  input  logic                  host_re_i,
  input  logic [DEPTH_LOG2-1:0] host_raddr_i,
  output logic [WORD_LEN-1:0]   host_rdata_o
);

  localparam int unsigned Depth = 1 << DEPTH_LOG2;

  logic [WORD_LEN-1:0] mem [Depth];
  logic [WORD_LEN-1:0] host_rdata_q;

  // No reset on the array itself; the parent's sweep clears it.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      host_rdata_q <= '0;
    end else if (host_re_i) begin
      host_rdata_q <= mem[host_raddr_i];
    end
  end

  assign rdata_o      = mem[raddr_i];
  assign host_rdata_o = host_rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// CPU data-memory responder with a clear-on-reset sweep and an idle-cycle host port.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int unsigned WORD_LEN   = DMEM_WORD_LEN,
  parameter int unsigned DEPTH_LOG2 = DMEM_DEPTH_LOG2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  Mem_Read_EN,
  input  logic                  Mem_Write_EN,
  input  logic [WORD_LEN-1:0]   ALU_Result,
  input  logic [WORD_LEN-1:0]   Store_Value,
  output logic [WORD_LEN-1:0]   Data_memory_out,
  input  logic                  host_valid,
  output logic                  host_ready,
  input  logic                  host_we,
  input  logic [DEPTH_LOG2-1:0] host_addr,
  input  logic [WORD_LEN-1:0]   host_wdata,
  output logic                  host_rvalid,
  output logic [WORD_LEN-1:0]   host_rdata,
  output logic                  init_done,
  output logic                  cpu_rw_conflict
);

  localparam logic [DEPTH_LOG2-1:0] LastIdx = '1;

  dmem_state_e           state_q;
  logic [DEPTH_LOG2-1:0] sweep_cnt_q;
  logic                  rvalid_q;
  logic                  conflict_q;

  logic                  run;
  logic                  host_fire;
  logic [DEPTH_LOG2-1:0] cpu_idx;
  logic                  mem_we;
  logic [DEPTH_LOG2-1:0] mem_waddr;
  logic [WORD_LEN-1:0]   mem_wdata;
  logic [WORD_LEN-1:0]   mem_rdata;
  logic                  unused_addr_bits;

  // Byte offset and high bits are dropped so CPU addresses alias modulo depth.
  assign cpu_idx          = ALU_Result[DEPTH_LOG2+1:2];
  assign unused_addr_bits = ^{ALU_Result[WORD_LEN-1:DEPTH_LOG2+2], ALU_Result[1:0]};

  assign run       = (state_q == StRun);
  assign host_fire = host_valid & host_ready;

  always_comb begin
    host_ready      = run & ~Mem_Read_EN & ~Mem_Write_EN;
    Data_memory_out = (run && Mem_Read_EN) ? mem_rdata : '0;
    mem_we          = 1'b0;
    mem_waddr       = cpu_idx;
    mem_wdata       = Store_Value;
    // Write priority: sweep, then CPU, then host.
    if (!run) begin
      mem_we    = 1'b1;
      mem_waddr = sweep_cnt_q;
      mem_wdata = '0;
    end else if (Mem_Write_EN) begin
      mem_we = 1'b1;
    end else if (host_fire && host_we) begin
      mem_we    = 1'b1;
      mem_waddr = host_addr;
      mem_wdata = host_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StInit;
      sweep_cnt_q <= '0;
      rvalid_q    <= 1'b0;
      conflict_q  <= 1'b0;
    end else begin
      rvalid_q <= host_fire & ~host_we;
      if (run && Mem_Read_EN && Mem_Write_EN) begin
        conflict_q <= 1'b1;
      end
      unique case (state_q)
        StInit: begin
          sweep_cnt_q <= sweep_cnt_q + 1'b1;
          if (sweep_cnt_q == LastIdx) begin
            state_q <= StRun;
          end
        end
        StRun: ;
      endcase
    end
  end

  dmem_array #(
    .WORD_LEN  (WORD_LEN),
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_array (
    .clk_i       (clk),
    .rst_ni      (rst),
    .we_i        (mem_we),
    .waddr_i     (mem_waddr),
    .wdata_i     (mem_wdata),
    .raddr_i     (cpu_idx),
    .rdata_o     (mem_rdata),
    .host_re_i   (host_fire & ~host_we),
    .host_raddr_i(host_addr),
    .host_rdata_o(host_rdata)
  );

  assign host_rvalid     = rvalid_q;
  assign init_done       = run;
  assign cpu_rw_conflict = conflict_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: init sweep, CPU/host access, arbitration, reset.
module tb_data_mem_responder;

  localparam int unsigned Depth = 256;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        Mem_Read_EN = 1'b0;
  logic        Mem_Write_EN = 1'b0;
  logic [31:0] ALU_Result = '0;
  logic [31:0] Store_Value = '0;
  logic [31:0] Data_memory_out;
  logic        host_valid = 1'b0;
  logic        host_ready;
  logic        host_we = 1'b0;
  logic [7:0]  host_addr = '0;
  logic [31:0] host_wdata = '0;
  logic        host_rvalid;
  logic [31:0] host_rdata;
  logic        init_done;
  logic        cpu_rw_conflict;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  data_mem_responder #(
    .WORD_LEN  (32),
    .DEPTH_LOG2(8)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .Mem_Read_EN    (Mem_Read_EN),
    .Mem_Write_EN   (Mem_Write_EN),
    .ALU_Result     (ALU_Result),
    .Store_Value    (Store_Value),
    .Data_memory_out(Data_memory_out),
    .host_valid     (host_valid),
    .host_ready     (host_ready),
    .host_we        (host_we),
    .host_addr      (host_addr),
    .host_wdata     (host_wdata),
    .host_rvalid    (host_rvalid),
    .host_rdata     (host_rdata),
    .init_done      (init_done),
    .cpu_rw_conflict(cpu_rw_conflict)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic wait_init(input string tag);
    int cyc = 0;
    int early_ready = 0;
    while (!init_done && cyc < 400) begin
      @(posedge clk);
      #1;
      cyc++;
      if (!init_done && host_ready) early_ready++;
    end
    check_eq({tag, "_cycles"}, cyc, 256);
    check_eq({tag, "_ready_early"}, early_ready, 0);
  endtask

  task automatic sweep_zero(input string tag);
    int nz = 0;
    for (int i = 0; i < Depth; i++) begin
      @(negedge clk);
      Mem_Read_EN = 1'b1;
      ALU_Result  = 32'(i * 4);
      #1;
      if (Data_memory_out !== 32'h0) nz++;
    end
    @(negedge clk);
    Mem_Read_EN = 1'b0;
    check_eq(tag, nz, 0);
  endtask

  task automatic cpu_write(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    Mem_Write_EN = 1'b1;
    ALU_Result   = addr;
    Store_Value  = data;
    @(negedge clk);
    Mem_Write_EN = 1'b0;
  endtask

  task automatic wait_ready(input string tag);
    int w = 0;
    #1;
    while (!host_ready && w < 50) begin
      @(negedge clk);
      #1;
      w++;
    end
    check_eq({tag, "_accept"}, host_ready, 1);
  endtask

  task automatic host_write(input logic [7:0] idx, input logic [31:0] data, input string tag);
    @(negedge clk);
    host_valid = 1'b1;
    host_we    = 1'b1;
    host_addr  = idx;
    host_wdata = data;
    wait_ready(tag);
    @(posedge clk);
    #1;
    check_eq({tag, "_no_rvalid"}, host_rvalid, 0);
    @(negedge clk);
    host_valid = 1'b0;
    host_we    = 1'b0;
  endtask

  task automatic host_read(input logic [7:0] idx, input logic [31:0] exp, input string tag);
    @(negedge clk);
    host_valid = 1'b1;
    host_we    = 1'b0;
    host_addr  = idx;
    wait_ready(tag);
    @(posedge clk);
    #1;
    check_eq({tag, "_rvalid"}, host_rvalid, 1);
    check_eq({tag, "_rdata"}, host_rdata, exp);
    @(negedge clk);
    host_valid = 1'b0;
    @(posedge clk);
    #1;
    check_eq({tag, "_rvalid_drop"}, host_rvalid, 0);
    check_eq({tag, "_rdata_hold"}, host_rdata, exp);
  endtask

  initial begin
    int blocked_ready;
    int early_pulses;

    // Reset state; a CPU read during INIT must still return 0.
    Mem_Read_EN = 1'b1;
    ALU_Result  = 32'h10;
    #12;
    check_eq("rst_init_done", init_done, 0);
    check_eq("rst_host_ready", host_ready, 0);
    check_eq("rst_rvalid", host_rvalid, 0);
    check_eq("rst_rdata", host_rdata, 0);
    check_eq("rst_conflict", cpu_rw_conflict, 0);
    check_eq("rst_dout", Data_memory_out, 0);
    Mem_Read_EN = 1'b0;

    @(negedge clk);
    rst = 1'b1;
    wait_init("init");
    sweep_zero("init_zero");
    host_read(8'd77, 32'h0, "init_host");

    // CPU store then load at an aliased byte offset the next cycle.
    @(negedge clk);
    Mem_Write_EN = 1'b1;
    ALU_Result   = 32'h10;
    Store_Value  = 32'hDEADBEEF;
    @(negedge clk);
    Mem_Write_EN = 1'b0;
    Mem_Read_EN  = 1'b1;
    ALU_Result   = 32'h13;
    #1;
    check_eq("st_ld_dout", Data_memory_out, 32'hDEADBEEF);
    check_eq("st_ld_ready", host_ready, 0);
    @(negedge clk);
    Mem_Read_EN = 1'b0;
    #1;
    check_eq("dout_idle", Data_memory_out, 0);

    // Byte address 0x400 wraps to word 0.
    cpu_write(32'h400, 32'h12345678);
    host_read(8'd0, 32'h12345678, "wrap_host");
    @(negedge clk);
    Mem_Read_EN = 1'b1;
    ALU_Result  = 32'h0;
    #1;
    check_eq("wrap_cpu", Data_memory_out, 32'h12345678);
    @(negedge clk);
    Mem_Read_EN = 1'b0;

    // Host read held off by three CPU loads.
    host_write(8'd5, 32'hA5A50005, "arb_prep");
    blocked_ready = 0;
    early_pulses  = 0;
    @(negedge clk);
    host_valid  = 1'b1;
    host_we     = 1'b0;
    host_addr   = 8'd5;
    Mem_Read_EN = 1'b1;
    for (int k = 0; k < 3; k++) begin
      ALU_Result = 32'(16 + k * 4);
      #1;
      if (host_ready) blocked_ready++;
      @(posedge clk);
      #1;
      if (host_rvalid) early_pulses++;
      @(negedge clk);
    end
    Mem_Read_EN = 1'b0;
    check_eq("arb_ready_blocked", blocked_ready, 0);
    check_eq("arb_no_early_rvalid", early_pulses, 0);
    #1;
    check_eq("arb_ready_after", host_ready, 1);
    @(posedge clk);
    #1;
    check_eq("arb_rvalid", host_rvalid, 1);
    check_eq("arb_rdata", host_rdata, 32'hA5A50005);
    @(negedge clk);
    host_valid = 1'b0;
    @(posedge clk);
    #1;
    check_eq("arb_rvalid_once", host_rvalid, 0);

    // Host write visible to the CPU port.
    host_write(8'd9, 32'hCAFEF00D, "hw");
    @(negedge clk);
    Mem_Read_EN = 1'b1;
    ALU_Result  = 32'h24;
    #1;
    check_eq("hw_cpu_read", Data_memory_out, 32'hCAFEF00D);
    @(negedge clk);
    Mem_Read_EN = 1'b0;

    // Simultaneous CPU read/write: old data out, new data committed, sticky flag.
    check_eq("conf_before", cpu_rw_conflict, 0);
    cpu_write(32'h20, 32'd7);
    @(negedge clk);
    Mem_Read_EN  = 1'b1;
    Mem_Write_EN = 1'b1;
    ALU_Result   = 32'h20;
    Store_Value  = 32'd9;
    #1;
    check_eq("conf_old_data", Data_memory_out, 32'd7);
    @(negedge clk);
    Mem_Write_EN = 1'b0;
    #1;
    check_eq("conf_new_data", Data_memory_out, 32'd9);
    check_eq("conf_flag", cpu_rw_conflict, 1);
    @(negedge clk);
    Mem_Read_EN = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("conf_sticky", cpu_rw_conflict, 1);

    // Reset while a host read is in flight.
    @(negedge clk);
    host_valid = 1'b1;
    host_we    = 1'b0;
    host_addr  = 8'd5;
    @(posedge clk);
    #1;
    check_eq("mid_pre_rvalid", host_rvalid, 1);
    #2;
    rst = 1'b0;
    #1;
    check_eq("mid_rvalid", host_rvalid, 0);
    check_eq("mid_init_done", init_done, 0);
    check_eq("mid_ready", host_ready, 0);
    check_eq("mid_conflict", cpu_rw_conflict, 0);
    check_eq("mid_rdata", host_rdata, 0);
    @(negedge clk);
    host_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    wait_init("reinit");
    sweep_zero("reinit_zero");
    host_read(8'd5, 32'h0, "reinit_host");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
